// File: rtl/fmlbrg_tagmem_flush_if.sv
// Bus bundle for the FML bridge tag memory: primary/secondary lookups, flush control
// and the write-back evict handshake. The primary tag output is do_o because "do" is a keyword.
interface fmlbrg_tagmem_flush_if #(
    parameter int depth  = 2,
    parameter int width  = 2,
    parameter int nports = 1
);
    logic [depth-1:0]        a;
    logic                    we;
    logic [width-1:0]        di;
    logic                    dirty_i;
    logic [width-1:0]        do_o;
    logic                    valid_o;
    logic                    dirty_o;
    logic [nports*depth-1:0] a2;
    logic [nports*width-1:0] do2;
    logic [nports-1:0]       valid2;
    logic                    flush;
    logic                    busy;
    logic                    evict_stb;
    logic                    evict_ack;
    logic [depth-1:0]        evict_idx;
    logic [width-1:0]        evict_tag;
    logic                    flush_done;

    modport master (
        output a, we, di, dirty_i, a2, flush, evict_ack,
        input  do_o, valid_o, dirty_o, do2, valid2, busy, evict_stb, evict_idx, evict_tag, flush_done
    );

    modport slave (
        input  a, we, di, dirty_i, a2, flush, evict_ack,
        output do_o, valid_o, dirty_o, do2, valid2, busy, evict_stb, evict_idx, evict_tag, flush_done
    );
endinterface

// File: rtl/fmlbrg_tagmem_flush.sv
// Tag memory with valid/dirty bits, N read-only lookup ports, a post-reset clearing
// sweep and a flush engine that hands dirty lines to write-back before invalidating them.
module fmlbrg_tagmem_flush #(
    parameter int depth  = 2,
    parameter int width  = 2,
    parameter int nports = 1
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    fmlbrg_tagmem_flush_if.slave bus
);
    localparam int LINES = 1 << depth;
    localparam int LW    = width + 2;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_EVICT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [depth-1:0] CNT_ONE  = depth'(1);
    localparam logic [depth-1:0] CNT_LAST = {depth{1'b1}};

    // Line layout: {valid, dirty, tag}
    logic [LW-1:0]           mem_r [LINES];
    logic [2:0]              state_r;
    logic [depth-1:0]        cnt_r;
    logic                    busy_r;
    logic                    evict_stb_r;
    logic [depth-1:0]        evict_idx_r;
    logic [width-1:0]        evict_tag_r;
    logic                    flush_done_r;
    logic [depth-1:0]        a_r;
    logic [nports*depth-1:0] a2_r;

    logic                    mem_we_s;
    logic [depth-1:0]        mem_wa_s;
    logic [LW-1:0]           mem_wd_s;
    logic [LW-1:0]           scan_line_s;
    logic                    evict_hit_s;
    logic [LW-1:0]           rd_line_s;
    logic [nports*width-1:0] do2_s;
    logic [nports-1:0]       valid2_s;

    assign scan_line_s = mem_r[cnt_r];
    assign evict_hit_s = scan_line_s[LW-1] & scan_line_s[width];
    assign rd_line_s   = mem_r[a_r];

    // Single array write port: sequencer clears take priority; host writes only when not busy.
    always_comb begin
        mem_we_s = 1'b0;
        mem_wa_s = cnt_r;
        mem_wd_s = {LW{1'b0}};
        case (state_r)
            ST_INIT: mem_we_s = 1'b1;
            ST_IDLE, ST_DONE: begin
                if (bus.we) begin
                    mem_we_s = 1'b1;
                    mem_wa_s = bus.a;
                    mem_wd_s = {1'b1, bus.dirty_i, bus.di};
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            ST_SCAN: begin
                if (evict_hit_s) mem_we_s = 1'b0;
                else             mem_we_s = 1'b1;
            end
            ST_EVICT: begin
                if (bus.evict_ack) mem_we_s = 1'b1;
                else               mem_we_s = 1'b0;
            end
            default: mem_we_s = 1'b0;
        endcase
    end

    // Tag array storage; contents are established by the init sweep, not by reset.
    always_ff @(posedge sys_clk) begin
        if (mem_we_s) mem_r[mem_wa_s] <= mem_wd_s;
    end

    // Lookup address registers for primary and secondary ports.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_r  <= {depth{1'b0}};
            a2_r <= {(nports*depth){1'b0}};
        end else begin
            a_r  <= bus.a;
            a2_r <= bus.a2;
        end
    end

    // Init sweep and flush sequencer; cnt only wraps to zero on a state exit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= ST_INIT;
            cnt_r        <= {depth{1'b0}};
            busy_r       <= 1'b1;
            evict_stb_r  <= 1'b0;
            evict_idx_r  <= {depth{1'b0}};
            evict_tag_r  <= {width{1'b0}};
            flush_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {depth{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (bus.flush) begin
                        state_r <= ST_SCAN;
                        cnt_r   <= {depth{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (evict_hit_s) begin
                        state_r     <= ST_EVICT;
                        evict_stb_r <= 1'b1;
                        evict_idx_r <= cnt_r;
                        evict_tag_r <= scan_line_s[width-1:0];
                    end else if (cnt_r == CNT_LAST) begin
                        state_r      <= ST_DONE;
                        cnt_r        <= {depth{1'b0}};
                        busy_r       <= 1'b0;
                        flush_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_EVICT: begin
                    if (bus.evict_ack) begin
                        evict_stb_r <= 1'b0;
                        if (cnt_r == CNT_LAST) begin
                            state_r      <= ST_DONE;
                            cnt_r        <= {depth{1'b0}};
                            busy_r       <= 1'b0;
                            flush_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_SCAN;
                            cnt_r   <= cnt_r + CNT_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    flush_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_INIT;
                    cnt_r        <= {depth{1'b0}};
                    busy_r       <= 1'b1;
                    evict_stb_r  <= 1'b0;
                    flush_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Secondary lookup ports read the live array at their registered indices.
    always_comb begin
        do2_s    = {(nports*width){1'b0}};
        valid2_s = {nports{1'b0}};
        for (int k = 0; k < nports; k++) begin
            do2_s[k*width +: width] = mem_r[a2_r[k*depth +: depth]][width-1:0];
            valid2_s[k]             = mem_r[a2_r[k*depth +: depth]][LW-1];
        end
    end

    assign bus.do_o       = rd_line_s[width-1:0];
    assign bus.valid_o    = rd_line_s[LW-1];
    assign bus.dirty_o    = rd_line_s[width];
    assign bus.do2        = do2_s;
    assign bus.valid2     = valid2_s;
    assign bus.busy       = busy_r;
    assign bus.evict_stb  = evict_stb_r;
    assign bus.evict_idx  = evict_idx_r;
    assign bus.evict_tag  = evict_tag_r;
    assign bus.flush_done = flush_done_r;
endmodule

// File: tb/tb_fmlbrg_tagmem_flush.sv
// Directed bench for fmlbrg_tagmem_flush (depth=2, width=4, nports=2): a write/read
// vector table plus hand-written flush, evict-handshake and reset-abort sequences.
module tb_fmlbrg_tagmem_flush;
    logic sys_clk;
    logic sys_rst_n;
    int   pass_cnt;
    int   total_cnt;
    int   done_pulses;
    int   stb_cycles;

    fmlbrg_tagmem_flush_if #(.depth(2), .width(4), .nports(2)) bif ();

    fmlbrg_tagmem_flush #(.depth(2), .width(4), .nports(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif)
    );

    typedef struct {
        logic [1:0] wa;
        logic [3:0] di;
        logic       dty;
        logic [1:0] ra;
        logic [3:0] tag;
        logic       vld;
        logic       drt;
    } vec_t;

    vec_t vecs [6];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (bif.flush_done === 1'b1) done_pulses <= done_pulses + 1;
        if (bif.evict_stb === 1'b1)  stb_cycles  <= stb_cycles + 1;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else             pass_cnt++;
    endtask

    task automatic wr(input logic [1:0] wa, input logic [3:0] di, input logic dty);
        bif.we = 1'b1; bif.a = wa; bif.di = di; bif.dirty_i = dty;
        step();
        bif.we = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bif.busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic check_invalid(input string name);
        for (int i = 0; i < 4; i++) begin
            bif.a  = 2'(i);
            bif.a2 = {2'(i), 2'(3 - i)};
            step();
            chk({name, "_valid_o"}, {31'd0, bif.valid_o}, 32'd0);
            chk({name, "_valid2"},  {30'd0, bif.valid2}, 32'd0);
        end
    endtask

    task automatic wait_stb(input string name);
        int n;
        n = 0;
        while (bif.evict_stb !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_stb_seen"}, {31'd0, bif.evict_stb}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bif.flush_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, {31'd0, bif.flush_done}, 32'd1);
    endtask

    // Delayed-ack handshake: strobe and payload must hold for two cycles before the ack.
    task automatic ack_evict(input string name, input logic [1:0] idx, input logic [3:0] tag);
        chk({name, "_idx"}, {30'd0, bif.evict_idx}, {30'd0, idx});
        chk({name, "_tag"}, {28'd0, bif.evict_tag}, {28'd0, tag});
        for (int i = 0; i < 2; i++) begin
            step();
            chk({name, "_stb_hold"}, {31'd0, bif.evict_stb}, 32'd1);
            chk({name, "_idx_hold"}, {30'd0, bif.evict_idx}, {30'd0, idx});
            chk({name, "_tag_hold"}, {28'd0, bif.evict_tag}, {28'd0, tag});
        end
        bif.evict_ack = 1'b1;
        step();
        bif.evict_ack = 1'b0;
        chk({name, "_stb_drop"}, {31'd0, bif.evict_stb}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int s0;
        pass_cnt = 0; total_cnt = 0; done_pulses = 0; stb_cycles = 0;
        vecs[0] = '{2'd1, 4'hA, 1'b0, 2'd1, 4'hA, 1'b1, 1'b0};
        vecs[1] = '{2'd0, 4'h5, 1'b1, 2'd0, 4'h5, 1'b1, 1'b1};
        vecs[2] = '{2'd2, 4'hF, 1'b1, 2'd2, 4'hF, 1'b1, 1'b1};
        vecs[3] = '{2'd3, 4'h0, 1'b0, 2'd1, 4'hA, 1'b1, 1'b0};
        vecs[4] = '{2'd2, 4'h6, 1'b0, 2'd3, 4'h0, 1'b1, 1'b0};
        vecs[5] = '{2'd0, 4'hC, 1'b0, 2'd2, 4'h6, 1'b1, 1'b0};

        sys_rst_n = 1'b0;
        bif.a = 2'd0; bif.we = 1'b0; bif.di = 4'h0; bif.dirty_i = 1'b0;
        bif.a2 = 4'h0; bif.flush = 1'b0; bif.evict_ack = 1'b0;
        step(); step(); step();

        // Reset state
        chk("rst_busy",       {31'd0, bif.busy},       32'd1);
        chk("rst_evict_stb",  {31'd0, bif.evict_stb},  32'd0);
        chk("rst_evict_idx",  {30'd0, bif.evict_idx},  32'd0);
        chk("rst_evict_tag",  {28'd0, bif.evict_tag},  32'd0);
        chk("rst_flush_done", {31'd0, bif.flush_done}, 32'd0);
        sys_rst_n = 1'b1;
        count_busy(n);
        chk("init_busy_cycles", 32'(n), 32'd4);
        check_invalid("init");

        // Table: write one line, then read a (possibly different) line on all ports
        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].wa, vecs[v].di, vecs[v].dty);
            bif.a  = vecs[v].ra;
            bif.a2 = {vecs[v].ra, vecs[v].ra};
            step();
            chk("vec_do",      {28'd0, bif.do_o},    {28'd0, vecs[v].tag});
            chk("vec_valid_o", {31'd0, bif.valid_o}, {31'd0, vecs[v].vld});
            chk("vec_dirty_o", {31'd0, bif.dirty_o}, {31'd0, vecs[v].drt});
            chk("vec_do2",     {24'd0, bif.do2},     {24'd0, vecs[v].tag, vecs[v].tag});
            chk("vec_valid2",  {30'd0, bif.valid2},  {30'd0, vecs[v].vld, vecs[v].vld});
        end

        // Clean flush: no strobes, exactly 4 busy cycles, single done pulse
        for (int i = 0; i < 4; i++) wr(2'(i), 4'(i + 1), 1'b0);
        d0 = done_pulses; s0 = stb_cycles;
        bif.flush = 1'b1;
        step();
        bif.flush = 1'b0;
        chk("clean_busy_start", {31'd0, bif.busy}, 32'd1);
        count_busy(n);
        chk("clean_busy_cycles", 32'(n), 32'd4);
        chk("clean_done_high", {31'd0, bif.flush_done}, 32'd1);
        step();
        chk("clean_done_low", {31'd0, bif.flush_done}, 32'd0);
        step();
        chk("clean_done_count", 32'(done_pulses - d0), 32'd1);
        chk("clean_no_stb", 32'(stb_cycles - s0), 32'd0);
        check_invalid("clean");

        // Dirty flush with delayed acks
        wr(2'd0, 4'h7, 1'b0);
        wr(2'd1, 4'h3, 1'b1);
        wr(2'd2, 4'h8, 1'b0);
        wr(2'd3, 4'hC, 1'b1);
        d0 = done_pulses;
        bif.flush = 1'b1;
        step();
        bif.flush = 1'b0;
        wait_stb("ev1");
        ack_evict("ev1", 2'd1, 4'h3);
        chk("ev1_no_done", 32'(done_pulses - d0), 32'd0);
        wait_stb("ev2");
        ack_evict("ev2", 2'd3, 4'hC);
        wait_done("ev");
        step();
        chk("ev_done_count", 32'(done_pulses - d0), 32'd1);
        check_invalid("ev");

        // we and a second flush while busy are both dropped
        d0 = done_pulses;
        bif.flush = 1'b1;
        step();
        bif.we = 1'b1; bif.a = 2'd2; bif.di = 4'h5; bif.dirty_i = 1'b1;
        n = 0;
        while (bif.busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        bif.we = 1'b0; bif.flush = 1'b0;
        chk("busywr_done", {31'd0, bif.flush_done}, 32'd1);
        step(); step(); step();
        chk("busywr_not_queued", {31'd0, bif.busy}, 32'd0);
        chk("busywr_done_count", 32'(done_pulses - d0), 32'd1);
        bif.a = 2'd2; bif.a2 = {2'd2, 2'd2};
        step();
        chk("busywr_line2_valid", {31'd0, bif.valid_o}, 32'd0);
        chk("busywr_line2_valid2", {30'd0, bif.valid2}, 32'd0);

        // Reset asserted while a strobe is outstanding
        wr(2'd0, 4'hE, 1'b1);
        bif.flush = 1'b1;
        step();
        bif.flush = 1'b0;
        wait_stb("rst");
        d0 = done_pulses;
        sys_rst_n = 1'b0;
        #1;
        chk("rstmid_stb", {31'd0, bif.evict_stb}, 32'd0);
        chk("rstmid_busy", {31'd0, bif.busy}, 32'd1);
        step();
        sys_rst_n = 1'b1;
        count_busy(n);
        chk("rstmid_init_cycles", 32'(n), 32'd4);
        step(); step();
        chk("rstmid_no_done", 32'(done_pulses - d0), 32'd0);
        check_invalid("rstmid");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/fmlbrg_tagmem_flush.md
# fmlbrg_tagmem_flush

Parametrised tag memory for the FML bridge cache, with per-line valid and dirty bits and any number of read-only lookup ports. It adds two sequencers: a self-clearing init sweep after reset, and a flush engine that walks every line, hands each dirty line to the write-back logic over a strobe/ack handshake, then invalidates it. It sits between the bridge controller (primary port, flush control), the snoop/lookup logic (secondary ports) and the write-back engine (evict handshake).

## Interface
Parameters:
- depth, 2: index bits; the array holds 2^depth lines.
- width, 2: tag bits per line.
- nports, 1: number of read-only secondary ports (1 or more).

Ports:
- sys_clk  in  1  single clock, all state on rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- a  in  depth  primary index.
- we  in  1  primary write enable; ignored while busy.
- di  in  width  tag to write.
- dirty_i  in  1  dirty bit written with di.
- do  out  width  tag of line at registered a.
- valid_o  out  1  valid bit of line at registered a.
- dirty_o  out  1  dirty bit of line at registered a.
- a2  in  nports*depth  secondary indices, port k at [k*depth +: depth].
- do2  out  nports*width  secondary tags, port k at [k*width +: width].
- valid2  out  nports  secondary valid bits.
- flush  in  1  flush request, sampled only in IDLE.
- busy  out  1  init or flush in progress.
- evict_stb  out  1  dirty line presented for write-back.
- evict_ack  in  1  write-back accepted.
- evict_idx  out  depth  index of evicted line.
- evict_tag  out  width  tag of evicted line.
- flush_done  out  1  one-cycle pulse, flush complete.

## Operation
- Line = {valid, dirty, tag}. Reads: address registered, array read combinationally at the registered address; a write at edge t is visible on any port addressing that line after edge t.
- Write (we=1, busy=0): line[a] <= {1, dirty_i, di}.
- FSM states INIT, IDLE, SCAN, EVICT, DONE; counter cnt (depth bits).
- INIT: line[cnt] <= 0, cnt++; after cnt = 2^depth-1, go IDLE.
- IDLE: flush=1 -> cnt<=0, SCAN.
- SCAN: line[cnt] valid&dirty -> latch evict_idx=cnt, evict_tag=tag, go EVICT. Otherwise clear line[cnt]; if cnt is last go DONE, else cnt++.
- EVICT: evict_stb=1, evict_idx/evict_tag held stable. On evict_ack=1: clear line[cnt], evict_stb<=0; if cnt last go DONE, else cnt++, SCAN.
- DONE: flush_done=1 for one cycle, go IDLE.
- busy = 1 in INIT, SCAN, EVICT; 0 in IDLE and DONE.
- Reads on all ports stay live while busy and return current array contents.

## Timing
- Reset values: state INIT, cnt 0, busy 1, evict_stb 0, evict_idx 0, evict_tag 0, flush_done 0; registered addresses 0. do/valid_o/dirty_o/do2/valid2 are undefined until the INIT sweep has passed their line, then 0.
- INIT lasts 2^depth cycles after reset release; busy falls on the following edge.
- Flush with no dirty lines: flush sampled at edge k; busy=1 from edge k to edge k+2^depth; flush_done=1 from edge k+2^depth to k+2^depth+1.
- Each dirty line adds 1 cycle for the SCAN->EVICT transition plus the ack wait. evict_ack already high on the first EVICT cycle gives a 1-cycle EVICT.
- evict_ack outside EVICT: ignored. flush while busy or in DONE: ignored; it is not queued.
- we and flush in the same IDLE cycle: the write completes, and the scan sees the written line.
- we during busy: dropped, no array change.
- sys_rst_n low mid-flush: evict_stb and busy reset immediately; no flush_done; a fresh INIT sweep starts.
- cnt wraps from 2^depth-1 to 0 only via a state exit; it is never left at an out-of-range value.

## Test plan
Bench parameters: depth=2, width=4, nports=2.
- Reset release -> busy=1 for 4 cycles, then 0; all valid_o/valid2 read 0 at indices 0..3.
- Write a=1, di=0xA, dirty_i=0, then set a=1, a2 port1=1 -> next cycle do=0xA, valid_o=1, dirty_o=0, do2[7:4]=0xA, valid2[1]=1.
- Write lines 0..3 clean, then flush -> busy for exactly 4 cycles, evict_stb never high, flush_done pulses once, all lines read invalid.
- Write dirty tags 0x3 at index 1 and 0xC at index 3, then flush with evict_ack delayed 2 cycles -> two strobes, {idx 1, tag 0x3} then {idx 3, tag 0xC}, each stable until ack; flush_done after the second ack; both lines end invalid.
- During busy, assert we at a=2 with di=0x5, plus a second flush pulse -> line 2 unchanged, only one flush_done.
- Pull sys_rst_n low while evict_stb=1 -> evict_stb=0 immediately, INIT sweep re-runs over 4 cycles, no flush_done.
